// File: rtl/fpu_ret_pkg.sv
// rtl/fpu_ret_pkg.sv - shared types, widths and lane helper for the FPU retire collector
package fpu_ret_pkg;

  localparam int FPU_RET_TAG_W = 14;
  localparam int FPU_RET_EXC_W = 11;

  typedef struct packed {
    logic [FPU_RET_TAG_W-1:0] tag;
    logic [FPU_RET_EXC_W-1:0] exc;
  } fpu_ret_entry_t;

  function automatic int lane_wrap(input int lane, input int lanes);
    return (lane + 1 >= lanes) ? 0 : lane + 1;
  endfunction

endpackage

// File: rtl/fpu_ret_fifo.sv
// rtl/fpu_ret_fifo.sv - single-lane show-ahead FIFO; dout is the head whenever !empty
module fpu_ret_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wr <= r_wr + AW'(1);
      if (pop)  r_rd <= r_rd + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr] <= din;
  end

  assign dout  = r_mem[r_rd];
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

endmodule

// File: rtl/fpu_ret_collect.sv
// rtl/fpu_ret_collect.sv - N-lane FPU retire/exception collector with round-robin multi-port drain
// Optional per-lane exception event counters: FPU_RET_EXC_CNT_EN
module fpu_ret_collect
  import fpu_ret_pkg::*;
#(
  parameter int LANES     = 3,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = FPU_RET_TAG_W,
  parameter int EXC_W     = FPU_RET_EXC_W,
  parameter int RET_PORTS = 2,
  localparam int LW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*TAG_W-1:0]    in_ret,
  input  logic [LANES-1:0]          in_ret_en,
  input  logic [LANES*EXC_W-1:0]    in_exc,
  output logic [LANES-1:0]          in_stall,
  output logic [RET_PORTS*TAG_W-1:0] out_ret,
  output logic [RET_PORTS*EXC_W-1:0] out_exc,
  output logic [RET_PORTS*LW-1:0]   out_lane,
  output logic [RET_PORTS-1:0]      out_valid,
  input  logic [RET_PORTS-1:0]      out_ready,
  output logic [EXC_W-1:0]          exc_sticky,
  input  logic                      exc_clr,
  output logic                      ovf,
  output logic [LANES*8-1:0]        exc_cnt
);

  localparam int W  = TAG_W + EXC_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]     w_dout  [LANES];
  logic [CW-1:0]    w_count [LANES];
  logic [LANES-1:0] w_empty;
  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;

  logic [LW-1:0]        w_sel [RET_PORTS];
  logic [RET_PORTS-1:0] w_valid;
  logic [EXC_W-1:0]     w_pop_exc;
  logic                 w_any_pop;
  logic [LW-1:0]        w_last;

  logic [LW-1:0]    r_rr;
  logic [EXC_W-1:0] r_sticky;
  logic             r_ovf;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fpu_ret_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[l]),
      .pop   (w_pop[l]),
      .din   ({in_ret[l*TAG_W +: TAG_W], in_exc[l*EXC_W +: EXC_W]}),
      .dout  (w_dout[l]),
      .empty (w_empty[l]),
      .full  (w_full[l]),
      .count (w_count[l])
    );
    // A full lane still accepts a push when it is being drained the same cycle.
    assign w_push[l]   = in_ret_en[l] & (~w_full[l] | w_pop[l]);
    assign in_stall[l] = (w_count[l] >= CW'(DEPTH - 1));
  end

  // Slot k takes the k-th non-empty lane found scanning from r_rr.
  always_comb begin
    int   pos;
    int   lane;
    logic found;
    w_valid   = '0;
    w_pop     = '0;
    w_pop_exc = '0;
    w_any_pop = 1'b0;
    w_last    = '0;
    pos       = 0;
    lane      = 0;
    found     = 1'b0;
    for (int k = 0; k < RET_PORTS; k++) w_sel[k] = '0;
    for (int k = 0; k < RET_PORTS; k++) begin
      found = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane = int'(r_rr) + i;
        if (lane >= LANES) lane = lane - LANES;
        if (!found && i >= pos && !w_empty[LW'(lane)]) begin
          found      = 1'b1;
          w_valid[k] = 1'b1;
          w_sel[k]   = LW'(lane);
          pos        = i + 1;
        end
      end
    end
    for (int k = 0; k < RET_PORTS; k++) begin
      if (w_valid[k] && out_ready[k]) begin
        w_pop[w_sel[k]] = 1'b1;
        w_pop_exc       = w_pop_exc | w_dout[w_sel[k]][EXC_W-1:0];
        w_any_pop       = 1'b1;
        w_last          = w_sel[k];
      end
    end
  end

  for (genvar k = 0; k < RET_PORTS; k++) begin : g_slot
    assign out_lane[k*LW +: LW]       = w_sel[k];
    assign out_ret[k*TAG_W +: TAG_W]  = w_valid[k] ? w_dout[w_sel[k]][W-1:EXC_W] : '0;
    assign out_exc[k*EXC_W +: EXC_W]  = w_valid[k] ? w_dout[w_sel[k]][EXC_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr     <= '0;
      r_sticky <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_any_pop) r_rr <= LW'(lane_wrap(int'(w_last), LANES));
      r_sticky <= (exc_clr ? '0 : r_sticky) | w_pop_exc;
      if (|(in_ret_en & w_full & ~w_pop)) r_ovf <= 1'b1;
    end
  end

  assign out_valid  = w_valid;
  assign exc_sticky = r_sticky;
  assign ovf        = r_ovf;

`ifdef FPU_RET_EXC_CNT_EN
  for (genvar l = 0; l < LANES; l++) begin : g_cnt
    logic [7:0] r_cnt;
    logic       w_ev;
    assign w_ev = w_pop[l] & (|w_dout[l][EXC_W-1:0]);
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_ev) begin
        r_cnt <= exc_clr ? 8'd1 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);
      end else if (exc_clr) begin
        r_cnt <= '0;
      end
    end
    assign exc_cnt[l*8 +: 8] = r_cnt;
  end
`else
  assign exc_cnt = '0;
`endif

  // Consumers must accept slots in order.
  for (genvar k = 1; k < RET_PORTS; k++) begin : g_order
    a_in_order: assert property (@(posedge clk) disable iff (rst) !(out_ready[k] && !out_ready[k-1]));
  end

endmodule
